interrupt_source_control: RTL and testbench

INTERRUPT_SOURCE_CONTROL -- requirements
Module: interrupt_source_control

---
 rtl/interrupt_source_control.sv | 187 ++++++++++++++++++
 tb/tb_interrupt_source_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_source_control.sv
// Interrupt and reset sequencer for a 6502C core: IRQ/NMI status registers,
// NMI pulse shaping and a stretched reset line.
module interrupt_source_control #(
    parameter int unsigned RES_CYCLES = 6,
    parameter int unsigned NMI_PULSE  = 2
) (
    input  logic       phi2,
    input  logic       rstAll_L,
    input  logic       cs,
    input  logic       nRW,
    input  logic [1:0] addr,
    input  logic [7:0] dataIn,
    output logic [7:0] dataOut,
    input  logic [7:0] irqSrc,
    input  logic [1:0] nmiSrc,
    input  logic       resetReq,
    output logic       NMI_L,
    output logic       IRQ_L,
    output logic       RES_L
);

    localparam logic [3:0] RES_LOAD = 4'(RES_CYCLES);
    localparam logic [1:0] NMI_LOAD = 2'(NMI_PULSE - 1);

    typedef enum logic [1:0] {NMI_IDLE, NMI_LOW, NMI_GAP} nmi_state_t;
    typedef enum logic {RES_HOLD, RES_RUN} res_state_t;

    nmi_state_t nmi_state_q, nmi_state_d;
    res_state_t res_state_q, res_state_d;
    logic [1:0] nmi_cnt_q, nmi_cnt_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic [3:0] res_cnt_q, res_cnt_d;
    logic [7:0] irqen_q, irqen_d;
    logic [7:0] irqst_q, irqst_d;
    logic [1:0] nmien_q, nmien_d;
    logic [1:0] nmist_q, nmist_d;
    logic [7:0] irq_dly_q;
    logic [1:0] nmi_dly_q;
    logic [7:0] data_out_q, data_out_d;
    logic       irq_l_q, irq_l_d;

    logic       wr_irqen, wr_irqclr, wr_nmien, wr_nmires, rd_en;
    logic       hold_now, hold_next;
    logic [7:0] irq_set;
    logic [1:0] nmi_set;
    logic       nmi_trig;

    assign wr_irqen  = cs && !nRW && (addr == 2'd0);
    assign wr_irqclr = cs && !nRW && (addr == 2'd1);
    assign wr_nmien  = cs && !nRW && (addr == 2'd2);
    assign wr_nmires = cs && !nRW && (addr == 2'd3);
    assign rd_en     = cs && nRW;

    assign hold_now  = (res_state_q == RES_HOLD);
    assign hold_next = (res_state_d == RES_HOLD);

    // Edges are qualified by the enable in force before this cycle's write.
    assign irq_set  = irqSrc & ~irq_dly_q & irqen_q;
    assign nmi_set  = nmiSrc & ~nmi_dly_q & nmien_q;
    assign nmi_trig = |nmi_set;

    // Reset sequencer next state
    always_comb begin
        res_state_d = res_state_q;
        res_cnt_d   = res_cnt_q;
        if (res_state_q == RES_HOLD) begin
            if (resetReq) begin
                res_cnt_d = RES_LOAD;
            end else if (res_cnt_q <= 4'd1) begin
                res_state_d = RES_RUN;
                res_cnt_d   = 4'd0;
            end else begin
                res_cnt_d = res_cnt_q - 4'd1;
            end
        end else if (resetReq) begin
            res_state_d = RES_HOLD;
            res_cnt_d   = RES_LOAD;
        end
    end

    // Register file; enables stay cleared for as long as reset is (or is about to be) held
    always_comb begin
        irqen_d = hold_next ? 8'h00 : (wr_irqen ? dataIn : irqen_q);
        nmien_d = hold_next ? 2'b00 : (wr_nmien ? dataIn[1:0] : nmien_q);

        irqst_d = irqst_q;
        if (wr_irqclr) begin
            irqst_d = irqst_d & ~dataIn;
        end
        irqst_d = (irqst_d | irq_set) & irqen_d;

        nmist_d = (wr_nmires ? 2'b00 : nmist_q) | nmi_set;

        irq_l_d = ~|(irqst_q & irqen_q);

        data_out_d = 8'h00;
        if (rd_en) begin
            case (addr)
                2'd0:    data_out_d = irqst_q;
                2'd2:    data_out_d = {6'b0, nmist_q};
                default: data_out_d = 8'h00;
            endcase
        end
    end

    // NMI pulse FSM next state; at most one pulse waits in nmi_pend_q
    always_comb begin
        nmi_state_d = nmi_state_q;
        nmi_cnt_d   = nmi_cnt_q;
        nmi_pend_d  = nmi_pend_q | nmi_trig;
        case (nmi_state_q)
            NMI_IDLE: begin
                if (nmi_pend_q) begin
                    nmi_state_d = NMI_LOW;
                    nmi_cnt_d   = NMI_LOAD;
                    nmi_pend_d  = 1'b0;
                end
            end
            NMI_LOW: begin
                if (nmi_cnt_q == 2'd0) begin
                    nmi_state_d = NMI_GAP;
                end else begin
                    nmi_cnt_d = nmi_cnt_q - 2'd1;
                end
            end
            NMI_GAP: begin
                if (nmi_pend_q) begin
                    nmi_state_d = NMI_LOW;
                    nmi_cnt_d   = NMI_LOAD;
                    nmi_pend_d  = 1'b0;
                end else begin
                    nmi_state_d = NMI_IDLE;
                end
            end
            default: begin
                nmi_state_d = NMI_IDLE;
                nmi_pend_d  = 1'b0;
            end
        endcase
        if (hold_now) begin
            nmi_state_d = NMI_IDLE;
            nmi_cnt_d   = 2'd0;
            nmi_pend_d  = 1'b0;
        end
    end

    // Output decode; the core sees no interrupts while its reset line is low
    always_comb begin
        RES_L   = (res_state_q == RES_RUN);
        NMI_L   = !RES_L || (nmi_state_q != NMI_LOW);
        IRQ_L   = !RES_L || irq_l_q;
        dataOut = data_out_q;
    end

    always_ff @(posedge phi2) begin
        if (!rstAll_L) begin
            res_state_q <= RES_HOLD;
            res_cnt_q   <= RES_LOAD;
            nmi_state_q <= NMI_IDLE;
            nmi_cnt_q   <= 2'd0;
            nmi_pend_q  <= 1'b0;
            irqen_q     <= 8'h00;
            irqst_q     <= 8'h00;
            nmien_q     <= 2'b00;
            nmist_q     <= 2'b00;
            irq_dly_q   <= irqSrc;
            nmi_dly_q   <= nmiSrc;
            data_out_q  <= 8'h00;
            irq_l_q     <= 1'b1;
        end else begin
            res_state_q <= res_state_d;
            res_cnt_q   <= res_cnt_d;
            nmi_state_q <= nmi_state_d;
            nmi_cnt_q   <= nmi_cnt_d;
            nmi_pend_q  <= nmi_pend_d;
            irqen_q     <= irqen_d;
            irqst_q     <= irqst_d;
            nmien_q     <= nmien_d;
            nmist_q     <= nmist_d;
            irq_dly_q   <= irqSrc;
            nmi_dly_q   <= nmiSrc;
            data_out_q  <= data_out_d;
            irq_l_q     <= irq_l_d;
        end
    end

endmodule

// File: tb/tb_interrupt_source_control.sv
// Directed bench for interrupt_source_control: register map, IRQ/NMI behaviour
// and the stretched reset sequence with default parameters.
module tb_interrupt_source_control;

    logic       phi2 = 1'b0;
    logic       rstAll_L;
    logic       cs;
    logic       nRW;
    logic [1:0] addr;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic [7:0] irqSrc;
    logic [1:0] nmiSrc;
    logic       resetReq;
    logic       NMI_L;
    logic       IRQ_L;
    logic       RES_L;

    int checks   = 0;
    int failures = 0;

    interrupt_source_control #(.RES_CYCLES(6), .NMI_PULSE(2)) dut (
        .phi2     (phi2),
        .rstAll_L (rstAll_L),
        .cs       (cs),
        .nRW      (nRW),
        .addr     (addr),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .irqSrc   (irqSrc),
        .nmiSrc   (nmiSrc),
        .resetReq (resetReq),
        .NMI_L    (NMI_L),
        .IRQ_L    (IRQ_L),
        .RES_L    (RES_L)
    );

    always #5 phi2 = ~phi2;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; nRW = 1'b0; addr = a; dataIn = d;
        tick();
        cs = 1'b0; nRW = 1'b1; dataIn = 8'h00;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        cs = 1'b1; nRW = 1'b1; addr = a;
        tick();
        cs = 1'b0;
        d = dataOut;
    endtask

    logic [7:0] rdat;
    logic [1:0] nmi_stim [9];
    logic       nmi_exp  [9];
    logic       dual_exp [4];

    initial begin
        rstAll_L = 1'b0; cs = 1'b0; nRW = 1'b1; addr = 2'd0; dataIn = 8'h00;
        irqSrc = 8'h00; nmiSrc = 2'b00; resetReq = 1'b0;

        // Power-on reset state, then RES_L low for exactly 6 cycles
        repeat (3) tick();
        chk("rst_res_l", 8'(RES_L), 8'h00);
        chk("rst_nmi_l", 8'(NMI_L), 8'h01);
        chk("rst_irq_l", 8'(IRQ_L), 8'h01);
        chk("rst_dataout", dataOut, 8'h00);
        rstAll_L = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_res_l", 8'(RES_L), 8'h00);
            chk("hold_nmi_l", 8'(NMI_L), 8'h01);
            chk("hold_irq_l", 8'(IRQ_L), 8'h01);
        end
        tick();
        chk("release_res_l", 8'(RES_L), 8'h01);

        // IRQ set, disabled edge discarded, clear, readback
        wr(2'd0, 8'h05);
        irqSrc = 8'h03;
        tick();
        chk("irq_l_before", 8'(IRQ_L), 8'h01);
        tick();
        chk("irq_l_set", 8'(IRQ_L), 8'h00);
        rd(2'd0, rdat);
        chk("irqst_01", rdat, 8'h01);
        wr(2'd1, 8'h01);
        chk("irq_l_clr_edge", 8'(IRQ_L), 8'h00);
        tick();
        chk("irq_l_clr_next", 8'(IRQ_L), 8'h01);
        rd(2'd0, rdat);
        chk("irqst_cleared", rdat, 8'h00);
        wr(2'd0, 8'h07);
        tick();
        rd(2'd0, rdat);
        chk("irqst_not_deferred", rdat, 8'h00);
        irqSrc = 8'h00;
        tick();

        // Simultaneous edge and IRQCLR leaves the bit set; IRQEN=0 clears it
        wr(2'd0, 8'h08);
        irqSrc = 8'h08;
        wr(2'd1, 8'h08);
        rd(2'd0, rdat);
        chk("irqst_set_wins", rdat, 8'h08);
        chk("irq_l_bit3", 8'(IRQ_L), 8'h00);
        wr(2'd0, 8'h00);
        rd(2'd0, rdat);
        chk("irqst_en_clear", rdat, 8'h00);
        chk("irq_l_en_clear", 8'(IRQ_L), 8'h01);
        irqSrc = 8'h00;
        tick();

        // NMI: pulse, queued second pulse, third edge merged
        wr(2'd2, 8'h02);
        nmi_stim = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        nmi_exp  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        nmiSrc = 2'b10;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("nmi_seq_%0d", i), 8'(NMI_L), 8'(nmi_exp[i]));
            nmiSrc = nmi_stim[i];
        end
        rd(2'd2, rdat);
        chk("nmist_02", rdat, 8'h02);
        wr(2'd3, 8'hFF);
        rd(2'd2, rdat);
        chk("nmist_res", rdat, 8'h00);
        rd(2'd1, rdat);
        chk("read_addr1", rdat, 8'h00);

        // Both NMI sources in one cycle: one pulse, both status bits
        wr(2'd2, 8'h03);
        nmiSrc = 2'b00;
        tick();
        nmiSrc = 2'b11;
        tick();
        chk("dual_pending", 8'(NMI_L), 8'h01);
        dual_exp = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("dual_seq_%0d", i), 8'(NMI_L), 8'(dual_exp[i]));
        end
        rd(2'd2, rdat);
        chk("nmist_03", rdat, 8'h03);

        // rstAll_L in the middle of a pulse aborts it
        nmiSrc = 2'b00;
        tick();
        nmiSrc = 2'b10;
        tick();
        tick();
        chk("abort_pre_low", 8'(NMI_L), 8'h00);
        rstAll_L = 1'b0;
        tick();
        chk("abort_nmi_l", 8'(NMI_L), 8'h01);
        chk("abort_res_l", 8'(RES_L), 8'h00);
        rstAll_L = 1'b1;
        repeat (6) tick();
        chk("abort_release", 8'(RES_L), 8'h01);
        rd(2'd2, rdat);
        chk("abort_nmist", rdat, 8'h00);
        nmiSrc = 2'b00;
        tick();
        nmiSrc = 2'b10;
        repeat (3) tick();
        chk("abort_nmien_off", 8'(NMI_L), 8'h01);

        // Soft reset, extended from within HOLD; sources high across it give no IRQ
        wr(2'd0, 8'hFF);
        resetReq = 1'b1;
        tick();
        resetReq = 1'b0;
        irqSrc = 8'hFF;
        chk("soft_s0", 8'(RES_L), 8'h00);
        wr(2'd0, 8'hFF);
        chk("soft_s1", 8'(RES_L), 8'h00);
        tick();
        chk("soft_s2", 8'(RES_L), 8'h00);
        resetReq = 1'b1;
        tick();
        resetReq = 1'b0;
        chk("soft_extend", 8'(RES_L), 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("soft_hold", 8'(RES_L), 8'h00);
        end
        tick();
        chk("soft_release", 8'(RES_L), 8'h01);
        tick();
        tick();
        chk("soft_irq_l", 8'(IRQ_L), 8'h01);
        rd(2'd0, rdat);
        chk("soft_irqst", rdat, 8'h00);
        wr(2'd0, 8'hFF);
        tick();
        tick();
        chk("soft_irq_l_en", 8'(IRQ_L), 8'h01);
        rd(2'd0, rdat);
        chk("soft_irqst_en", rdat, 8'h00);
        irqSrc = 8'hFE;
        tick();
        irqSrc = 8'hFF;
        tick();
        rd(2'd0, rdat);
        chk("soft_fresh_edge", rdat, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
